// File: rtl/acs_unit.sv
// ---------------------------------------------------------------------------
// acs_unit -- add-compare-select stage for a 4-state (two-bit memory) trellis
//
// Each cycle with valid_in high, the eight candidate metrics are reduced
// to one survivor per destination state. The survivors are normalized so
// that the smallest is 0, then registered. A small FSM counts trellis
// stages and pulses frame_done on the last stage of each frame.
//
// Ports
//   clk                   rising-edge clock
//   rst_n                 asynchronous active-low reset
//   refresh               synchronous clear, overrides valid_in
//   valid_in              candidate metrics valid this cycle
//   branch_metric_ab_y    candidate metric from state ab on input bit y
//   pm_00 .. pm_11        registered normalized survivor path metrics
//   decision[i]           MSB of the survivor predecessor of state i
//   best_state            lowest-index state holding the minimum metric
//   valid_out             pm/decision/best_state were updated this cycle
//   frame_done            one-cycle pulse alongside the last stage's valid_out
// ---------------------------------------------------------------------------
module acs_unit #(
  parameter int MW        = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          refresh,
  input  logic          valid_in,
  input  logic [MW-1:0] branch_metric_00_0,
  input  logic [MW-1:0] branch_metric_00_1,
  input  logic [MW-1:0] branch_metric_01_0,
  input  logic [MW-1:0] branch_metric_01_1,
  input  logic [MW-1:0] branch_metric_10_0,
  input  logic [MW-1:0] branch_metric_10_1,
  input  logic [MW-1:0] branch_metric_11_0,
  input  logic [MW-1:0] branch_metric_11_1,
  output logic [MW-1:0] pm_00,
  output logic [MW-1:0] pm_01,
  output logic [MW-1:0] pm_10,
  output logic [MW-1:0] pm_11,
  output logic [3:0]    decision,
  output logic [1:0]    best_state,
  output logic          valid_out,
  output logic          frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, stage_nx;

  logic [MW-1:0] sel_00, sel_01, sel_10, sel_11;
  logic [MW-1:0] min_lo, min_hi, min_all;
  logic [3:0]    dec_c;
  logic [1:0]    best_c;

  // Compare-select. Destination state "by" is reached from "0b" and "1b" on
  // input bit y. A strict compare means ties keep the MSB-0 predecessor.
  always_comb begin
    dec_c[0] = branch_metric_10_0 < branch_metric_00_0;
    dec_c[1] = branch_metric_10_1 < branch_metric_00_1;
    dec_c[2] = branch_metric_11_0 < branch_metric_01_0;
    dec_c[3] = branch_metric_11_1 < branch_metric_01_1;

    sel_00 = dec_c[0] ? branch_metric_10_0 : branch_metric_00_0;
    sel_01 = dec_c[1] ? branch_metric_10_1 : branch_metric_00_1;
    sel_10 = dec_c[2] ? branch_metric_11_0 : branch_metric_01_0;
    sel_11 = dec_c[3] ? branch_metric_11_1 : branch_metric_01_1;

    min_lo  = (sel_01 < sel_00) ? sel_01 : sel_00;
    min_hi  = (sel_11 < sel_10) ? sel_11 : sel_10;
    min_all = (min_hi < min_lo) ? min_hi : min_lo;

    // Priority chain so that equal minima resolve to the lowest index.
    if (sel_00 == min_all)      best_c = 2'd0;
    else if (sel_01 == min_all) best_c = 2'd1;
    else if (sel_10 == min_all) best_c = 2'd2;
    else                        best_c = 2'd3;
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_00      <= '0;
      pm_01      <= '0;
      pm_10      <= '0;
      pm_11      <= '0;
      decision   <= '0;
      best_state <= '0;
      valid_out  <= 1'b0;
    end else if (refresh) begin
      pm_00      <= '0;
      pm_01      <= '0;
      pm_10      <= '0;
      pm_11      <= '0;
      decision   <= '0;
      best_state <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        // Every selected metric is >= min_all, so these never underflow.
        pm_00      <= sel_00 - min_all;
        pm_01      <= sel_01 - min_all;
        pm_10      <= sel_10 - min_all;
        pm_11      <= sel_11 - min_all;
        decision   <= dec_c;
        best_state <= best_c;
      end
    end
  end

  // Frame tracking. A valid stage arriving in IDLE or DONE begins a new
  // frame, so counting restarts from 0 there; DONE itself lasts one cycle.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_nx = ((state_q == RUN) ? cnt_q : '0) + CW'(1);
    if (refresh) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (valid_in) begin
      cnt_d   = stage_nx;
      state_d = (stage_nx == CW'(FRAME_LEN)) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE is entered exactly on the edge that registers the last stage.
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_acs_unit.sv
// ---------------------------------------------------------------------------
// tb_acs_unit -- self-checking bench for acs_unit (MW=4, FRAME_LEN=4).
// The reference model computes survivors from the trellis rules directly
// (predecessors 0b/1b of state by) and counts frame stages arithmetically.
// ---------------------------------------------------------------------------
module tb_acs_unit;

  localparam int MW = 4;
  localparam int FL = 4;
  localparam int OW = 4 * MW + 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            refresh;
  logic            valid_in;
  logic [8*MW-1:0] cv;  // candidate k = {a,b,y} lives at cv[k*MW +: MW]

  logic [MW-1:0] pm_00, pm_01, pm_10, pm_11;
  logic [3:0]    decision;
  logic [1:0]    best_state;
  logic          valid_out, frame_done;
  logic [OW-1:0] act;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_pm [4];
  int m_dec;
  int m_best;
  int m_cnt;
  bit m_vout;
  bit m_done;

  always #5 clk = ~clk;

  acs_unit #(.MW(MW), .FRAME_LEN(FL)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .refresh            (refresh),
    .valid_in           (valid_in),
    .branch_metric_00_0 (cv[0*MW +: MW]),
    .branch_metric_00_1 (cv[1*MW +: MW]),
    .branch_metric_01_0 (cv[2*MW +: MW]),
    .branch_metric_01_1 (cv[3*MW +: MW]),
    .branch_metric_10_0 (cv[4*MW +: MW]),
    .branch_metric_10_1 (cv[5*MW +: MW]),
    .branch_metric_11_0 (cv[6*MW +: MW]),
    .branch_metric_11_1 (cv[7*MW +: MW]),
    .pm_00              (pm_00),
    .pm_01              (pm_01),
    .pm_10              (pm_10),
    .pm_11              (pm_11),
    .decision           (decision),
    .best_state         (best_state),
    .valid_out          (valid_out),
    .frame_done         (frame_done)
  );

  assign act = {pm_11, pm_10, pm_01, pm_00, decision, best_state, valid_out, frame_done};

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_pm[s] = 0;
    m_dec  = 0;
    m_best = 0;
    m_cnt  = 0;
    m_vout = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock edge of the reference: survivors, normalization, frame count.
  task automatic model_stage(input logic [8*MW-1:0] c, input bit v, input bit rf);
    int sel [4];
    int c0, c1, mn;
    if (rf) begin
      model_reset();
    end else begin
      m_vout = v;
      m_done = 1'b0;
      if (v) begin
        m_dec = 0;
        for (int d = 0; d < 4; d++) begin
          // destination d = {b,y}; predecessors {0,b} and {1,b}, input y
          c0 = int'(c[(d) * MW +: MW]);       // from state 0b
          c1 = int'(c[(4 + d) * MW +: MW]);   // from state 1b
          if (c1 < c0) begin
            sel[d] = c1;
            m_dec  = m_dec + (1 << d);
          end else begin
            sel[d] = c0;
          end
        end
        mn = sel[0];
        for (int d = 1; d < 4; d++) if (sel[d] < mn) mn = sel[d];
        m_best = -1;
        for (int d = 0; d < 4; d++) begin
          m_pm[d] = sel[d] - mn;
          if (m_best < 0 && m_pm[d] == 0) m_best = d;
        end
        m_cnt = m_cnt + 1;
        if (m_cnt == FL) begin
          m_done = 1'b1;
          m_cnt  = 0;
        end
      end
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    return {MW'(m_pm[3]), MW'(m_pm[2]), MW'(m_pm[1]), MW'(m_pm[0]),
            4'(m_dec), 2'(m_best), m_vout, m_done};
  endfunction

  function automatic logic [8*MW-1:0] rand_cv();
    logic [8*MW-1:0] c;
    for (int k = 0; k < 8; k++) c[k*MW +: MW] = MW'($urandom_range(0, (1 << MW) - 1));
    return c;
  endfunction

  // Drive at the falling edge, let one rising edge happen, settle 1 ns.
  task automatic step(input logic [8*MW-1:0] c, input bit v, input bit rf);
    @(negedge clk);
    cv       = c;
    valid_in = v;
    refresh  = rf;
    @(posedge clk);
    model_stage(c, v, rf);
    #1;
  endtask

  task automatic test_reset();
    logic [OW-1:0] e;
    #2;
    n_vec++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL reset_initial: got %h expected %h", act, {OW{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(rand_cv(), 1'b1, 1'b0);
    step(rand_cv(), 1'b1, 1'b0);
    step(rand_cv(), 1'b0, 1'b0);
    e = exp_vec();
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL pre_reset_run: got %h expected %h", act, e);
    end
    // assert reset mid-cycle, well away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", act, {OW{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    // abandoned frame: a fresh frame needs FL full stages
    for (int i = 0; i < FL; i++) begin
      step(rand_cv(), 1'b1, 1'b0);
      e = exp_vec();
      n_vec++;
      if (act !== e || frame_done !== (i == FL - 1)) begin
        n_err++;
        $display("FAIL post_reset_frame[%0d]: got %h expected %h", i, act, e);
      end
    end
  endtask

  task automatic test_select();
    logic [OW-1:0] e;
    logic [8*MW-1:0] c;
    // 11_1,11_0,10_1,10_0,01_1,01_0,00_1,00_0
    c = {4'd2, 4'd2, 4'd0, 4'd4, 4'd2, 4'd2, 4'd3, 4'd1};
    step(c, 1'b1, 1'b0);
    e = exp_vec();
    n_vec++;
    if (act !== e || act[OW-1:1] !== {4'd2, 4'd2, 4'd0, 4'd1, 4'b0010, 2'b01, 1'b1}) begin
      n_err++;
      $display("FAIL select_normalize: got %h expected %h", act, e);
    end
    step(rand_cv(), 1'b0, 1'b0);
    e = exp_vec();
    n_vec++;
    if (act !== e || valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL select_hold: got %h expected %h", act, e);
    end
  endtask

  task automatic test_ties();
    logic [OW-1:0] e;
    step({8{4'd3}}, 1'b1, 1'b0);
    e = exp_vec();
    n_vec++;
    if (act !== e || act[OW-1:1] !== {16'h0000, 4'b0000, 2'b00, 1'b1}) begin
      n_err++;
      $display("FAIL ties: got %h expected %h", act, e);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] e;
    for (int i = 0; i < 60; i++) begin
      step(rand_cv(), $urandom_range(0, 3) != 0, 1'b0);
      e = exp_vec();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL random[%0d]: got %h expected %h", i, act, e);
      end
    end
  endtask

  task automatic test_frame();
    logic [OW-1:0] e;
    bit v_pat  [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    bit fd_pat [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    step(rand_cv(), 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step(rand_cv(), v_pat[i], 1'b0);
      e = exp_vec();
      n_vec++;
      if (act !== e || frame_done !== fd_pat[i]) begin
        n_err++;
        $display("FAIL frame[%0d]: got %h expected %h (frame_done want %0b)", i, act, e, fd_pat[i]);
      end
    end
  endtask

  task automatic test_refresh();
    logic [OW-1:0] e;
    step(rand_cv(), 1'b0, 1'b1);
    step(rand_cv(), 1'b1, 1'b0);
    step(rand_cv(), 1'b1, 1'b0);
    step(rand_cv(), 1'b1, 1'b1);
    n_vec++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL refresh_clear: got %h expected %h", act, {OW{1'b0}});
    end
    for (int i = 0; i < FL; i++) begin
      step(rand_cv(), 1'b1, 1'b0);
      e = exp_vec();
      n_vec++;
      if (act !== e || frame_done !== (i == FL - 1)) begin
        n_err++;
        $display("FAIL refresh_frame[%0d]: got %h expected %h", i, act, e);
      end
    end
  endtask

  // Upstream stage: rate-1/2 (7,5) encoder branch outputs versus a random
  // received hard-decision pair; candidate = path metric + Hamming distance.
  task automatic test_closed_loop();
    logic [OW-1:0]   e;
    logic [8*MW-1:0] c;
    int r, o, bm, mx, mn;
    step(rand_cv(), 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 3));
      for (int s = 0; s < 4; s++) begin
        for (int y = 0; y < 2; y++) begin
          o  = (((y ^ (s >> 1) ^ (s & 1)) & 1) << 1) | ((y ^ (s >> 1)) & 1);
          bm = $countones(2'(o ^ r));
          c[(s * 2 + y) * MW +: MW] = MW'(m_pm[s] + bm);
        end
      end
      step(c, $urandom_range(0, 4) != 0, 1'b0);
      e = exp_vec();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL closed_loop[%0d]: got %h expected %h", i, act, e);
      end
      mx = int'(pm_00);
      mn = int'(pm_00);
      if (int'(pm_01) > mx) mx = int'(pm_01);
      if (int'(pm_10) > mx) mx = int'(pm_10);
      if (int'(pm_11) > mx) mx = int'(pm_11);
      if (int'(pm_01) < mn) mn = int'(pm_01);
      if (int'(pm_10) < mn) mn = int'(pm_10);
      if (int'(pm_11) < mn) mn = int'(pm_11);
      n_vec++;
      if (mx > 4 || mn != 0) begin
        n_err++;
        $display("FAIL closed_loop_bound[%0d]: got max %0d min %0d, expected max<=4 min 0", i, mx, mn);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    refresh  = 1'b0;
    valid_in = 1'b0;
    cv       = '0;
    model_reset();
    test_reset();
    test_select();
    test_ties();
    test_random();
    test_frame();
    test_refresh();
    test_closed_loop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
